// File: rtl/scmp_bus_pak.sv
// Shared types and default constants for the SC/MP bus responder slice.
package scmp_bus_pak;

    // Default decode window: the low 4 KiB of the 16-bit address space.
    localparam int unsigned DEF_AW      = 16;
    localparam logic [15:0] DEF_BASE    = 16'h0000;
    localparam logic [15:0] DEF_MASK    = 16'hF000;

    // Default number of cycles to wait for mem_ack before forcing completion.
    localparam logic [7:0]  DEF_TIMEOUT = 8'd64;

    // Value returned to the CPU when a read times out.
    localparam logic [7:0]  RD_TIMEOUT_DATA = 8'hFF;

    // Responder bus-cycle states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        RD_REQ = 3'd2,
        RD_DRV = 3'd3,
        WR_REQ = 3'd4,
        END    = 3'd5
    } BUS_STATE_t;

    // Cycle flags in the same order as the sequencer drives them.
    typedef struct packed {
        logic h;   // halt
        logic d;   // delay
        logic i;   // instruction fetch
        logic r;   // read
    } BUS_FLAGS_t;

endpackage

// File: rtl/scmp_bus_timeout.sv
// Clear/enable cycle counter that flags the last permitted wait cycle.
module scmp_bus_timeout
    import scmp_bus_pak::*;
#(
    parameter logic [7:0] TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    // Count enabled cycles; clear has priority so a new wait always starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    // Expiry is only meaningful while a wait is in progress.
    assign expired = en && (count == TIMEOUT - 8'd1);

endmodule

// File: rtl/scmp_bus_responder.sv
// Target-side SC/MP bus agent: latches the address on ADS, decodes a window,
// and turns each selected bus read/write into one req/ack memory transaction,
// stretching the CPU cycle with bus_HOLD until the memory (or a timeout) completes.
module scmp_bus_responder
    import scmp_bus_pak::*;
#(
    parameter int unsigned   AW      = DEF_AW,
    parameter logic [AW-1:0] BASE    = DEF_BASE,
    parameter logic [AW-1:0] MASK    = DEF_MASK,
    parameter logic [7:0]    TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bus_ADS_n,
    input  logic          bus_RD_n,
    input  logic          bus_WR_n,
    input  logic          bus_F_R,
    input  logic          bus_F_I,
    input  logic          bus_F_D,
    input  logic          bus_F_H,
    input  logic [AW-1:0] bus_addr,
    input  logic [7:0]    bus_D_in,
    output logic [7:0]    bus_D_out,
    output logic          bus_D_oe,
    output logic          bus_HOLD,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ack,
    output logic          halt_o,
    output logic          ifetch_o,
    output logic          bus_err
);

    BUS_STATE_t state;
    BUS_FLAGS_t bus_flags;
    BUS_FLAGS_t flags_q;
    logic       sel_q;
    logic       addr_hit;
    logic       in_wait;
    logic       tmo_expired;
    logic       flags_unused;

    assign bus_flags = '{h: bus_F_H, d: bus_F_D, i: bus_F_I, r: bus_F_R};
    assign addr_hit  = ((bus_addr & MASK) == BASE);
    assign in_wait   = (state == RD_REQ) || (state == WR_REQ);
    assign ifetch_o  = flags_q.i;

    // Halt is consumed at ADS time; read/delay are carried only for visibility.
    assign flags_unused = &{1'b0, flags_q.h, flags_q.d, flags_q.r};

    // Wait counter: held clear outside the request states, so every request starts at zero.
    scmp_bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_wait),
        .en      (in_wait),
        .expired (tmo_expired)
    );

    // Bus-cycle sequencer and its registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // in this block updates from the values present before the edge.
            state     <= IDLE;
            flags_q   <= '0;
            sel_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            bus_HOLD  <= 1'b0;
            bus_D_out <= 8'h00;
            bus_D_oe  <= 1'b0;
            halt_o    <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            halt_o <= 1'b0;

            // A new address strobe mid-cycle is a protocol error; the address is dropped.
            if (!bus_ADS_n && (state != IDLE)) begin
                bus_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!bus_ADS_n) begin
                        mem_addr <= bus_addr;
                        flags_q  <= bus_flags;
                        sel_q    <= addr_hit;
                        halt_o   <= addr_hit && bus_flags.h;
                        state    <= ADDR;
                    end
                end

                ADDR: begin
                    if (!bus_RD_n && !bus_WR_n) begin
                        bus_err <= 1'b1;
                        state   <= END;
                    end else if (!bus_RD_n) begin
                        if (sel_q) begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            bus_HOLD <= 1'b1;
                            state    <= RD_REQ;
                        end else begin
                            state <= END;
                        end
                    end else if (!bus_WR_n) begin
                        mem_wdata <= bus_D_in;
                        if (sel_q) begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b1;
                            bus_HOLD <= 1'b1;
                            state    <= WR_REQ;
                        end else begin
                            state <= END;
                        end
                    end
                end

                // HOLD is left high for one more cycle after completion so the
                // CPU sees the read data driven before its cycle is released.
                RD_REQ: begin
                    if (mem_ack) begin
                        bus_D_out <= mem_rdata;
                        bus_D_oe  <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        state     <= RD_DRV;
                    end else if (tmo_expired) begin
                        bus_D_out <= RD_TIMEOUT_DATA;
                        bus_D_oe  <= 1'b1;
                        bus_err   <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        state     <= RD_DRV;
                    end
                end

                RD_DRV: begin
                    bus_HOLD <= 1'b0;
                    if (bus_RD_n) begin
                        bus_D_oe <= 1'b0;
                        flags_q  <= '0;
                        state    <= IDLE;
                    end
                end

                WR_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= END;
                    end else if (tmo_expired) begin
                        bus_err <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= END;
                    end
                end

                END: begin
                    bus_HOLD <= 1'b0;
                    if (bus_RD_n && bus_WR_n) begin
                        flags_q <= '0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scmp_bus_responder.sv
// Directed testbench for scmp_bus_responder with a small scripted memory responder.
module tb_scmp_bus_responder;
    import scmp_bus_pak::*;

    logic        clk;
    logic        rst;
    logic        bus_ADS_n, bus_RD_n, bus_WR_n;
    logic        bus_F_R, bus_F_I, bus_F_D, bus_F_H;
    logic [15:0] bus_addr;
    logic [7:0]  bus_D_in;
    logic [7:0]  bus_D_out;
    logic        bus_D_oe, bus_HOLD;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        halt_o, ifetch_o, bus_err;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Results of the last serve_mem run.
    int          req_cycles, hold_cycles;
    bit          stable_ok, serve_done;
    logic [15:0] addr_seen;
    logic [7:0]  wdata_seen;
    logic        we_seen;

    scmp_bus_responder dut (
        .clk(clk), .rst(rst),
        .bus_ADS_n(bus_ADS_n), .bus_RD_n(bus_RD_n), .bus_WR_n(bus_WR_n),
        .bus_F_R(bus_F_R), .bus_F_I(bus_F_I), .bus_F_D(bus_F_D), .bus_F_H(bus_F_H),
        .bus_addr(bus_addr), .bus_D_in(bus_D_in),
        .bus_D_out(bus_D_out), .bus_D_oe(bus_D_oe), .bus_HOLD(bus_HOLD),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .halt_o(halt_o), .ifetch_o(ifetch_o), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic idle_bus();
        bus_ADS_n = 1'b1; bus_RD_n = 1'b1; bus_WR_n = 1'b1;
        bus_F_R = 1'b0; bus_F_I = 1'b0; bus_F_D = 1'b0; bus_F_H = 1'b0;
        bus_addr = 16'h0000; bus_D_in = 8'h00; mem_rdata = 8'h00; mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One-cycle ADS pulse; the address is then scrambled to show it is latched.
    task automatic ads(input logic [15:0] addr, input logic h, input logic i);
        bus_ADS_n = 1'b0; bus_addr = addr; bus_F_H = h; bus_F_I = i;
        @(posedge clk); #1;
        bus_ADS_n = 1'b1; bus_F_H = 1'b0; bus_F_I = 1'b0; bus_addr = 16'hFFFF;
    endtask

    // Memory model: acks on the ack_after-th mem_req cycle (0 = never), runs
    // until HOLD has risen and fallen, optionally pulses ADS after sample glitch_at.
    task automatic serve_mem(input int ack_after, input int budget, input int glitch_at);
        bit seen_hold;
        seen_hold = 1'b0;
        req_cycles = 0; hold_cycles = 0; stable_ok = 1'b1; serve_done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            bus_ADS_n = 1'b1;
            if (mem_req) begin
                if (req_cycles == 0) begin
                    addr_seen = mem_addr; we_seen = mem_we; wdata_seen = mem_wdata;
                end else if (mem_addr !== addr_seen || mem_we !== we_seen || mem_wdata !== wdata_seen) begin
                    stable_ok = 1'b0;
                end
                req_cycles++;
            end
            if (bus_HOLD) begin
                hold_cycles++;
                seen_hold = 1'b1;
            end else if (seen_hold) begin
                serve_done = 1'b1;
                break;
            end
            mem_ack = (ack_after > 0) && mem_req && (req_cycles == ack_after);
            if (i == glitch_at) begin
                bus_ADS_n = 1'b0; bus_addr = 16'h0200;
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_bus();
        rst = 1'b1;
        @(posedge clk); #1;
        n_compared++; if ({mem_req, mem_we, bus_HOLD, bus_D_oe, halt_o, ifetch_o, bus_err} !== 7'b0) begin
            n_mismatched++; $display("FAIL reset_ctrl: got %b want 0000000", {mem_req, mem_we, bus_HOLD, bus_D_oe, halt_o, ifetch_o, bus_err}); end
        n_compared++; if ({bus_D_out, mem_wdata, mem_addr} !== 32'h0) begin
            n_mismatched++; $display("FAIL reset_data: got %h want 00000000", {bus_D_out, mem_wdata, mem_addr}); end
        n_compared++; if (dut.state !== IDLE) begin
            n_mismatched++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
        #1 rst = 1'b0;
    endtask

    task automatic test_read_selected();
        mem_rdata = 8'h5A;
        ads(16'h0123, 1'b0, 1'b0);
        bus_RD_n = 1'b0;
        serve_mem(3, 20, -1);
        n_compared++; if (serve_done !== 1'b1) begin n_mismatched++; $display("FAIL rd_done: got %0d want 1", serve_done); end
        n_compared++; if (req_cycles !== 3) begin n_mismatched++; $display("FAIL rd_req_cycles: got %0d want 3", req_cycles); end
        n_compared++; if (hold_cycles !== 4) begin n_mismatched++; $display("FAIL rd_hold_cycles: got %0d want 4", hold_cycles); end
        n_compared++; if ({we_seen, addr_seen} !== {1'b0, 16'h0123}) begin
            n_mismatched++; $display("FAIL rd_we_addr: got %b/%h want 0/0123", we_seen, addr_seen); end
        n_compared++; if (stable_ok !== 1'b1) begin n_mismatched++; $display("FAIL rd_stable: got %0d want 1", stable_ok); end
        n_compared++; if ({bus_D_oe, bus_D_out, bus_err} !== {1'b1, 8'h5A, 1'b0}) begin
            n_mismatched++; $display("FAIL rd_data: got oe=%b d=%h err=%b want oe=1 d=5a err=0", bus_D_oe, bus_D_out, bus_err); end
        @(posedge clk); #1;
        n_compared++; if (bus_D_oe !== 1'b1) begin n_mismatched++; $display("FAIL rd_oe_held: got %b want 1", bus_D_oe); end
        bus_RD_n = 1'b1;
        @(posedge clk); #1;
        n_compared++; if ({bus_D_oe, dut.state} !== {1'b0, IDLE}) begin
            n_mismatched++; $display("FAIL rd_release: got oe=%b st=%0d want oe=0 st=0", bus_D_oe, dut.state); end
    endtask

    task automatic test_write_zero_wait();
        bus_D_in = 8'hC3;
        ads(16'h0FFF, 1'b0, 1'b0);
        bus_WR_n = 1'b0;
        serve_mem(1, 20, -1);
        bus_D_in = 8'h00;
        n_compared++; if ({serve_done, 8'(req_cycles), 8'(hold_cycles)} !== {1'b1, 8'd1, 8'd2}) begin
            n_mismatched++; $display("FAIL wr_timing: got done=%0d req=%0d hold=%0d want 1/1/2", serve_done, req_cycles, hold_cycles); end
        n_compared++; if ({we_seen, wdata_seen, addr_seen} !== {1'b1, 8'hC3, 16'h0FFF}) begin
            n_mismatched++; $display("FAIL wr_fields: got %b/%h/%h want 1/c3/0fff", we_seen, wdata_seen, addr_seen); end
        n_compared++; if ({bus_D_oe, bus_err, mem_req} !== 3'b000) begin
            n_mismatched++; $display("FAIL wr_after: got %b want 000", {bus_D_oe, bus_err, mem_req}); end
        bus_WR_n = 1'b1;
        @(posedge clk); #1;
        n_compared++; if (dut.state !== IDLE) begin n_mismatched++; $display("FAIL wr_idle: got %0d want 0", dut.state); end
    endtask

    task automatic test_read_unselected();
        bit activity;
        activity = 1'b0;
        ads(16'h1000, 1'b1, 1'b0);
        n_compared++; if (halt_o !== 1'b0) begin n_mismatched++; $display("FAIL unsel_halt: got %b want 0", halt_o); end
        bus_RD_n = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (mem_req || bus_HOLD || bus_D_oe) activity = 1'b1;
        end
        n_compared++; if (activity !== 1'b0) begin n_mismatched++; $display("FAIL unsel_quiet: got %b want 0", activity); end
        bus_RD_n = 1'b1;
        @(posedge clk); #1;
        n_compared++; if (dut.state !== IDLE) begin n_mismatched++; $display("FAIL unsel_idle: got %0d want 0", dut.state); end
    endtask

    task automatic test_read_timeout();
        mem_rdata = 8'h5A;
        ads(16'h0123, 1'b0, 1'b0);
        bus_RD_n = 1'b0;
        serve_mem(0, 100, -1);
        n_compared++; if ({serve_done, 8'(req_cycles), 8'(hold_cycles)} !== {1'b1, 8'd64, 8'd65}) begin
            n_mismatched++; $display("FAIL tmo_timing: got done=%0d req=%0d hold=%0d want 1/64/65", serve_done, req_cycles, hold_cycles); end
        n_compared++; if ({bus_D_oe, bus_D_out, bus_err} !== {1'b1, 8'hFF, 1'b1}) begin
            n_mismatched++; $display("FAIL tmo_data: got oe=%b d=%h err=%b want 1/ff/1", bus_D_oe, bus_D_out, bus_err); end
        bus_RD_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_compared++; if (bus_err !== 1'b1) begin n_mismatched++; $display("FAIL tmo_sticky: got %b want 1", bus_err); end
    endtask

    task automatic test_halt_ifetch();
        do_reset();
        mem_rdata = 8'h11;
        ads(16'h0010, 1'b1, 1'b1);
        n_compared++; if ({halt_o, ifetch_o} !== 2'b11) begin n_mismatched++; $display("FAIL halt_pulse: got %b want 11", {halt_o, ifetch_o}); end
        @(posedge clk); #1;
        n_compared++; if ({halt_o, ifetch_o} !== 2'b01) begin n_mismatched++; $display("FAIL halt_single: got %b want 01", {halt_o, ifetch_o}); end
        bus_RD_n = 1'b0;
        serve_mem(1, 20, -1);
        n_compared++; if ({serve_done, ifetch_o, bus_D_out} !== {1'b1, 1'b1, 8'h11}) begin
            n_mismatched++; $display("FAIL halt_fetch: got done=%b if=%b d=%h want 1/1/11", serve_done, ifetch_o, bus_D_out); end
        bus_RD_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_rd_wr_conflict();
        bit saw_req;
        saw_req = 1'b0;
        ads(16'h0123, 1'b0, 1'b0);
        bus_RD_n = 1'b0; bus_WR_n = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (mem_req || bus_HOLD) saw_req = 1'b1;
        end
        n_compared++; if ({bus_err, saw_req} !== 2'b10) begin
            n_mismatched++; $display("FAIL conflict: got err=%b req=%b want 1/0", bus_err, saw_req); end
        bus_RD_n = 1'b1; bus_WR_n = 1'b1;
        @(posedge clk); #1;
        n_compared++; if (dut.state !== IDLE) begin n_mismatched++; $display("FAIL conflict_idle: got %0d want 0", dut.state); end
    endtask

    task automatic test_ads_during_request();
        do_reset();
        mem_rdata = 8'h77;
        ads(16'h0123, 1'b0, 1'b0);
        bus_RD_n = 1'b0;
        serve_mem(3, 20, 1);
        n_compared++; if ({serve_done, 8'(req_cycles), stable_ok, addr_seen} !== {1'b1, 8'd3, 1'b1, 16'h0123}) begin
            n_mismatched++; $display("FAIL ads_mid_req: got done=%0d req=%0d stable=%0d addr=%h want 1/3/1/0123", serve_done, req_cycles, stable_ok, addr_seen); end
        n_compared++; if ({bus_D_out, bus_err} !== {8'h77, 1'b1}) begin
            n_mismatched++; $display("FAIL ads_mid_data: got d=%h err=%b want 77/1", bus_D_out, bus_err); end
        bus_RD_n = 1'b1;
        @(posedge clk); #1;
        n_compared++; if (dut.state !== IDLE) begin n_mismatched++; $display("FAIL ads_mid_idle: got %0d want 0", dut.state); end
    endtask

    task automatic test_reset_mid_transaction();
        do_reset();
        ads(16'h0123, 1'b0, 1'b0);
        bus_RD_n = 1'b0;
        @(posedge clk); #1;
        n_compared++; if ({mem_req, bus_HOLD} !== 2'b11) begin n_mismatched++; $display("FAIL rstmid_pre: got %b want 11", {mem_req, bus_HOLD}); end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_compared++; if ({mem_req, bus_HOLD, bus_D_oe} !== 3'b000) begin
            n_mismatched++; $display("FAIL rstmid_async: got %b want 000", {mem_req, bus_HOLD, bus_D_oe}); end
        bus_RD_n = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        mem_rdata = 8'h3C;
        ads(16'h0456, 1'b0, 1'b0);
        bus_RD_n = 1'b0;
        serve_mem(1, 20, -1);
        n_compared++; if ({serve_done, 8'(req_cycles), addr_seen, bus_D_out, bus_err} !== {1'b1, 8'd1, 16'h0456, 8'h3C, 1'b0}) begin
            n_mismatched++; $display("FAIL rstmid_next: got done=%0d req=%0d addr=%h d=%h err=%b want 1/1/0456/3c/0", serve_done, req_cycles, addr_seen, bus_D_out, bus_err); end
        bus_RD_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_read_selected();
        test_write_zero_wait();
        test_read_unselected();
        test_read_timeout();
        test_halt_ifetch();
        test_rd_wr_conflict();
        test_ads_during_request();
        test_reset_mid_transaction();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/scmp_bus_responder.md
Name: scmp_bus_responder

Overview:
Target-side agent for the SC/MP external bus, driven by the microcode sequencer's ADS/RD/WR strobes and F_R/F_I/F_D/F_H flags.
- Latches address and flags on ADS, decodes a selectable window, and converts each bus read/write into a single req/ack transaction on a synchronous memory port.
- Stretches the CPU cycle with bus_HOLD until the memory completes or a timeout fires.
- Sits between the CPU bus and RAM/ROM/peripheral models in the top level.

Parameters:
AW, 16, address width.
BASE, 16'h0000, decode base address.
MASK, 16'hF000, decode mask; selected when (addr & MASK) == BASE.
TIMEOUT, 8'd64, max cycles waiting for mem_ack before a forced completion.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
bus_ADS_n  in  1  address strobe, active low.
bus_RD_n  in  1  read strobe, active low.
bus_WR_n  in  1  write strobe, active low.
bus_F_R, bus_F_I, bus_F_D, bus_F_H  in  1 each  cycle flags: read, instruction fetch, delay, halt. Valid with ADS.
bus_addr  in  AW  address, valid while ADS_n is low.
bus_D_in  in  8  CPU write data.
bus_D_out  out  8  read data to CPU.
bus_D_oe  out  1  read-data drive enable.
bus_HOLD  out  1  stretch request; CPU holds its strobe while this is high.
mem_req  out  1  transaction request, held until ack.
mem_we  out  1  1 = write.
mem_addr  out  AW  latched address.
mem_wdata  out  8  latched write data.
mem_rdata  in  8  read data, valid with mem_ack.
mem_ack  in  1  one-cycle completion.
halt_o  out  1  one-cycle pulse on a selected ADS with F_H=1.
ifetch_o  out  1  latched F_I of the current cycle.
bus_err  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset values: all outputs 0; bus_D_out 8'h00; state IDLE; timeout counter 0.
- States: IDLE, ADDR, RD_REQ, RD_DRV, WR_REQ, END.
- IDLE, on ADS_n=0 sampled at a rising edge:
  - Latch addr, flags, and sel = decode hit.
  - Go to ADDR.
  - If sel and F_H, pulse halt_o on the next cycle.
- ADDR:
  - RD_n=0, WR_n=1: if sel, go to RD_REQ and assert mem_req/mem_we=0 plus bus_HOLD in the same registered cycle. If not sel, go to END with no outputs.
  - WR_n=0, RD_n=1: latch bus_D_in; if sel, go to WR_REQ with mem_req/mem_we=1 plus HOLD; else go to END.
  - RD_n=0 and WR_n=0 together: set bus_err, go to END, no memory access.
- RD_REQ:
  - mem_req and HOLD stay high; the counter increments each cycle.
  - On mem_ack: capture mem_rdata into bus_D_out, drop mem_req and HOLD, assert D_oe, go to RD_DRV.
  - On counter == TIMEOUT-1 without ack: bus_D_out = 8'hFF, set bus_err, drop req/HOLD, go to RD_DRV.
- RD_DRV: D_oe stays high while RD_n=0. On RD_n=1, drop D_oe and go to IDLE.
- WR_REQ:
  - Same ack/timeout handling as RD_REQ.
  - On completion, drop req/HOLD and go to END.
- END: wait for RD_n=1 and WR_n=1, then go to IDLE.
- Latency: mem_req rises 1 cycle after the strobe is sampled low. HOLD falls on the cycle after mem_ack is sampled, so with a zero-wait memory the minimum HOLD length is 2 cycles.
- mem_addr and mem_wdata are stable for the full duration of mem_req.
- The counter clears on entry to RD_REQ/WR_REQ.
- ADS_n low in any state other than IDLE: set bus_err and ignore the new address. An outstanding transaction always completes.
- mem_ack outside RD_REQ/WR_REQ is ignored.
- Address decode is registered on the ADS edge, so changes to bus_addr after ADS have no effect.
- rst mid-transaction: immediate return to reset values. mem_req drops asynchronously and the memory side must tolerate the abandoned request.

Decomposition:
- Package scmp_bus_pak:
  - BUS_STATE_t enum (six states above).
  - BUS_FLAGS_t packed struct {h,d,i,r}, matching the flag order of the existing bus outputs.
  - Default constants for TIMEOUT and the decode window.
- One natural sub-module, scmp_bus_timeout: clear/enable counter with an expire flag, parameterised by TIMEOUT.

Test Plan:
- Read, selected addr 16'h0123, memory acks after 3 cycles with 8'h5A -> mem_req high 3 cycles with mem_addr=16'h0123, HOLD high 4 cycles, D_out=8'h5A with D_oe until RD_n rises, bus_err=0.
- Write 8'hC3 to 16'h0FFF, ack after 0 wait -> one mem_req cycle with mem_we=1 and mem_wdata=8'hC3; HOLD falls 2 cycles after WR_n is sampled low.
- Read at 16'h1000 (unselected) -> no mem_req, HOLD=0, D_oe=0; state returns to IDLE after RD_n rises.
- Read with mem_ack never asserted, TIMEOUT=64 -> HOLD released after 64 cycles, D_out=8'hFF, bus_err=1 and stays set.
- ADS with F_H=1 and F_I=1 at 16'h0010 -> halt_o exactly one-cycle pulse, ifetch_o=1 for the cycle.
- RD_n and WR_n low together -> bus_err=1 and no mem_req. Also: rst asserted during RD_REQ -> mem_req, HOLD, D_oe go to 0 immediately, and the next ADS is accepted normally.
